// File: rtl/gf_exp_seq_pkg.sv
// Shared definitions for the GF(2^8) exponent sequencer.
package gf_exp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiplicative group order of GF(2^8); exponents live in 0..254.
    localparam int unsigned GF_ORDER_M1 = 255;

    // Primitive polynomial x^8 + x^4 + x^3 + x^2 + 1.
    localparam logic [8:0] GF_POLY = 9'h11D;

    // Multiply a field element by alpha (x), reducing by the primitive polynomial.
    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/gf_exp_seq_if.sv
// Request/response bundle for the exponent sequencer: run request in, beat stream out.
interface gf_exp_seq_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic [7:0]       base;
    logic [7:0]       stride;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_exp;
    logic [7:0]       out_data;
    logic             out_last;
    logic             done;

    // Requester / sink side.
    modport master (
        output start, base, stride, count, out_ready,
        input  busy, out_valid, out_exp, out_data, out_last, done
    );

    // Sequencer side.
    modport slave (
        input  start, base, stride, count, out_ready,
        output busy, out_valid, out_exp, out_data, out_last, done
    );
endinterface

// File: rtl/gf_exp_seq_gf_exp.sv
// Combinational exponent lookup: data = alpha^exp_in in GF(2^8).
module gf_exp_seq_gf_exp
    import gf_exp_seq_pkg::*;
(
    input  logic [7:0] exp_in,
    output logic [7:0] data
);

    // Table is built at elaboration by repeated multiplication by alpha;
    // entry 255 wraps back to 1, which keeps the table total.
    function automatic logic [255:0][7:0] build_tbl();
        logic [255:0][7:0] t;
        logic [7:0]        a;
        a = 8'h01;
        for (int i = 0; i < 256; i++) begin
            t[i] = a;
            a    = gf_mul_alpha(a);
        end
        return t;
    endfunction

    localparam logic [255:0][7:0] EXP_TBL = build_tbl();

    assign data = EXP_TBL[exp_in];

endmodule

// File: rtl/gf_exp_seq.sv
// Emits a run of alpha^(base + k*stride mod 255) beats over a valid/ready stream.
module gf_exp_seq
    import gf_exp_seq_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    gf_exp_seq_if.slave bus
);

    state_t           state;
    logic [7:0]       exp_r;
    logic [7:0]       stride_r;
    logic [CNT_W-1:0] remaining;
    logic             busy_r;
    logic             valid_r;
    logic             last_r;
    logic             done_r;
    logic [7:0]       data_w;

    // 0xFF is congruent to 0 mod 255; every other 8-bit value is already reduced.
    function automatic logic [7:0] reduce255(input logic [7:0] x);
        return (x == 8'hFF) ? 8'h00 : x;
    endfunction

    // Add two reduced exponents modulo 255 using a 9-bit sum and one conditional subtract.
    function automatic logic [7:0] mod_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 9'(GF_ORDER_M1)) begin
            sum = sum - 9'(GF_ORDER_M1);
        end
        return sum[7:0];
    endfunction

    // Run-control FSM with registered status outputs and beat state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exp_r     <= 8'h00;
            stride_r  <= 8'h00;
            remaining <= '0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.count == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state     <= RUN;
                            valid_r   <= 1'b1;
                            exp_r     <= reduce255(bus.base);
                            stride_r  <= reduce255(bus.stride);
                            remaining <= bus.count;
                            last_r    <= (bus.count == CNT_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (bus.out_ready) begin
                        exp_r     <= mod_add(exp_r, stride_r);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state   <= DONE;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            last_r <= (remaining == CNT_W'(2));
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    gf_exp_seq_gf_exp u_gf_exp (
        .exp_in (exp_r),
        .data   (data_w)
    );

    assign bus.busy      = busy_r;
    assign bus.out_valid = valid_r;
    assign bus.out_exp   = exp_r;
    assign bus.out_data  = data_w;
    assign bus.out_last  = last_r;
    assign bus.done      = done_r;

endmodule
